arbitro_buffer_circular: RTL and testbench

- Round-robin write arbiter and access sequencer in front of the shared circular buffer (BufferCircular).
- NREQ producers contend for the buffer's single insertion port. One consumer pops through a paced delete port.
- The block drives insercion/dato/delecion into the buffer and gates on its llena/vacia flags.
- All buffer-facing outputs are registered.

---
 rtl/arbitro_buffer_circular.sv | 154 +++++++++++++++
 tb/tb_arbitro_buffer_circular.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_buffer_circular.sv
// Round-robin write arbiter and paced delete sequencer in front of the circular buffer.
// Optional macro ARB_CONTADORES_EN adds per-producer 16-bit saturating grant counters.
module arbitro_buffer_circular #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDX   = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] dato_req_i,
    output logic [NREQ-1:0]       ack_o,
    output logic [IDX-1:0]        grant_o,
    input  logic                  leer_i,
    input  logic                  llena_i,
    input  logic                  vacia_i,
    output logic                  insercion_o,
    output logic [WIDTH-1:0]      dato_o,
    output logic                  delecion_o
`ifdef ARB_CONTADORES_EN
    ,
    input  logic                  borrar_cnt_i,
    output logic [NREQ*16-1:0]    cuenta_o
`endif
);

    typedef enum logic [1:0] {StReposo, StInserta, StEspera} w_state_e;
    typedef enum logic [1:0] {StRReposo, StRBorra, StREspera} r_state_e;

    w_state_e w_q, w_d;
    r_state_e r_q, r_d;

    logic [IDX-1:0]   ptr_q, ptr_d;
    logic [IDX-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             insercion_q, insercion_d;
    logic [WIDTH-1:0] dato_q, dato_d;
    logic             delecion_q, delecion_d;

    logic [WIDTH-1:0] datos [NREQ];
    logic             found;
    logic [IDX-1:0]   sel;
    logic [IDX-1:0]   pos;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign datos[k] = dato_req_i[k*WIDTH +: WIDTH];
    end

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        pos   = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = IDX'((int'(ptr_q) + i) % NREQ);
            if (!found && req_i[pos]) begin
                found = 1'b1;
                sel   = pos;
            end
        end
    end

    always_comb begin
        w_d         = w_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        ack_d       = '0;
        insercion_d = 1'b0;
        dato_d      = dato_q;
        unique case (w_q)
            StReposo: begin
                if (found && !llena_i) begin
                    insercion_d = 1'b1;
                    dato_d      = datos[sel];
                    ack_d       = NREQ'(1) << sel;
                    grant_d     = sel;
                    ptr_d       = (sel == IDX'(NREQ - 1)) ? '0 : sel + 1'b1;
                    w_d         = StInserta;
                end
            end
            StInserta: w_d = StEspera;
            StEspera:  w_d = StReposo;
            default:   w_d = StReposo;
        endcase
    end

    always_comb begin
        r_d        = r_q;
        delecion_d = 1'b0;
        unique case (r_q)
            StRReposo: begin
                if (leer_i && !vacia_i) begin
                    delecion_d = 1'b1;
                    r_d        = StRBorra;
                end
            end
            StRBorra:  r_d = StREspera;
            StREspera: r_d = StRReposo;
            default:   r_d = StRReposo;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            w_q         <= StReposo;
            r_q         <= StRReposo;
            ptr_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            insercion_q <= 1'b0;
            dato_q      <= '0;
            delecion_q  <= 1'b0;
        end else begin
            w_q         <= w_d;
            r_q         <= r_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            insercion_q <= insercion_d;
            dato_q      <= dato_d;
            delecion_q  <= delecion_d;
        end
    end

    assign ack_o       = ack_q;
    assign grant_o     = grant_q;
    assign insercion_o = insercion_q;
    assign dato_o      = dato_q;
    assign delecion_o  = delecion_q;

`ifdef ARB_CONTADORES_EN
    logic [15:0] cnt_q [NREQ];

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (borrar_cnt_i) begin
                    cnt_q[k] <= '0;
                end else if (ack_q[k] && cnt_q[k] != 16'hFFFF) begin
                    cnt_q[k] <= cnt_q[k] + 16'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_cuenta
        assign cuenta_o[k*16 +: 16] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_arbitro_buffer_circular.sv
// Self-checking bench for arbitro_buffer_circular with a behavioural 8-entry buffer occupancy model.
module tb_arbitro_buffer_circular;

    localparam int WIDTH = 64;
    localparam int NREQ  = 4;
    localparam int IDX   = 2;
    localparam int NUM   = 8;

    logic                  clk_i = 1'b0;
    logic                  rstn_i = 1'b0;
    logic [NREQ-1:0]       req_i = '0;
    logic [NREQ*WIDTH-1:0] dato_req_i = '0;
    logic [NREQ-1:0]       ack_o;
    logic [IDX-1:0]        grant_o;
    logic                  leer_i = 1'b0;
    logic                  llena_i;
    logic                  vacia_i;
    logic                  insercion_o;
    logic [WIDTH-1:0]      dato_o;
    logic                  delecion_o;
`ifdef ARB_CONTADORES_EN
    logic                  borrar_cnt_i = 1'b0;
    logic [NREQ*16-1:0]    cuenta_o;
`endif

    arbitro_buffer_circular #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .dato_req_i  (dato_req_i),
        .ack_o       (ack_o),
        .grant_o     (grant_o),
        .leer_i      (leer_i),
        .llena_i     (llena_i),
        .vacia_i     (vacia_i),
        .insercion_o (insercion_o),
        .dato_o      (dato_o),
        .delecion_o  (delecion_o)
`ifdef ARB_CONTADORES_EN
        ,
        .borrar_cnt_i(borrar_cnt_i),
        .cuenta_o    (cuenta_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Buffer occupancy model
    logic       buf_rstn = 1'b0;
    logic [4:0] occ;
    always @(posedge clk_i or negedge buf_rstn) begin
        if (!buf_rstn) occ <= '0;
        else occ <= occ + 5'(insercion_o) - 5'(delecion_o);
    end
    assign llena_i = (occ == 5'(NUM));
    assign vacia_i = (occ == 5'd0);

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t mk(input int idx, input logic [63:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        return e;
    endfunction

    task automatic set_data(input int k, input logic [63:0] d);
        dato_req_i[k*WIDTH +: WIDTH] = d;
    endtask

    // Waits (bounded) for a negedge with ack_o non-zero.
    task automatic wait_ack(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_i);
            if (ack_o != '0) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic reset_all();
        @(negedge clk_i);
        rstn_i   = 1'b0;
        buf_rstn = 1'b0;
        req_i    = '0;
        leer_i   = 1'b0;
        sb.delete();
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_all();
        checks++;
        if ({insercion_o, delecion_o, ack_o, grant_o} !== '0 || dato_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ins=%b del=%b ack=%b grant=%0d dato=%h, required all zero",
                     insercion_o, delecion_o, ack_o, grant_o, dato_o);
        end
    endtask

    task automatic test_round_robin();
        bit got;
        exp_t e;
        int last;
        reset_all();
        for (int k = 0; k < NREQ; k++) set_data(k, 64'(16 + k));
        req_i = 4'b1111;
        @(negedge clk_i);
        rstn_i   = 1'b1;
        buf_rstn = 1'b1;
        last = cyc;
        for (int n = 0; n < 5; n++) sb.push_back(mk(n % NREQ, 64'(16 + (n % NREQ))));
        for (int n = 0; n < 5; n++) begin
            wait_ack(20, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rr_timeout: no ack for grant %0d, required ack within 20 cycles", n);
                break;
            end
            e = sb.pop_front();
            checks++;
            if (ack_o !== (4'b1 << e.idx) || grant_o !== 2'(e.idx) || dato_o !== e.data
                || insercion_o !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant%0d: ack=%b grant=%0d dato=%h ins=%b, required ack=%b grant=%0d dato=%h ins=1",
                         n, ack_o, grant_o, dato_o, insercion_o, 4'b1 << e.idx, e.idx, e.data);
            end
            checks++;
            if (cyc - last !== ((n == 0) ? 1 : 3)) begin
                errors++;
                $display("FAIL rr_spacing%0d: %0d cycles, required %0d", n, cyc - last, (n == 0) ? 1 : 3);
            end
            last = cyc;
        end
        req_i = '0;
    endtask

    task automatic test_single_full();
        bit got;
        exp_t e;
        int bad;
        reset_all();
        set_data(2, 64'hAB);
        req_i = 4'b0100;
        @(negedge clk_i);
        rstn_i   = 1'b1;
        buf_rstn = 1'b1;
        for (int n = 0; n < NUM; n++) begin
            sb.push_back(mk(2, 64'hAB));
            wait_ack(20, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL single_timeout: no ack for insert %0d, required ack within 20 cycles", n);
                break;
            end
            e = sb.pop_front();
            if (ack_o !== (4'b1 << e.idx) || grant_o !== 2'(e.idx) || dato_o !== e.data) begin
                errors++;
                $display("FAIL single_grant%0d: ack=%b grant=%0d dato=%h, required ack=0100 grant=2 dato=%h",
                         n, ack_o, grant_o, dato_o, e.data);
            end
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (insercion_o !== 1'b0 || ack_o !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_hold: %0d cycles with insert/ack while full, required 0", bad);
        end
    endtask

    // Continues from the full buffer left by test_single_full (ptr saved at 3).
    task automatic test_drain_from_full();
        bit got;
        exp_t e;
        int pulses;
        set_data(0, 64'h10);
        set_data(3, 64'h13);
        req_i  = 4'b1001;
        leer_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            if (delecion_o === 1'b1) got = 1'b1;
        end
        leer_i = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL drain_delete: delecion_o=0 for 10 cycles, required one pulse");
        end
        pulses = 0;
        sb.push_back(mk(3, 64'h13));
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            if (delecion_o === 1'b1) pulses++;
            if (ack_o != '0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL drain_timeout: no ack after delete, required ack within 20 cycles");
        end else begin
            e = sb.pop_front();
            checks++;
            if (ack_o !== (4'b1 << e.idx) || grant_o !== 2'(e.idx) || dato_o !== e.data) begin
                errors++;
                $display("FAIL drain_grant: ack=%b grant=%0d dato=%h, required ack=1000 grant=3 dato=%h",
                         ack_o, grant_o, dato_o, e.data);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL drain_extra_delete: %0d extra pulses, required 0", pulses);
        end
        req_i = '0;
    endtask

    task automatic test_empty_read();
        bit got;
        exp_t e;
        int pulses;
        reset_all();
        rstn_i   = 1'b1;
        buf_rstn = 1'b1;
        leer_i   = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (delecion_o !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL empty_no_delete: %0d pulses while empty, required 0", pulses);
        end
        set_data(0, 64'h5A);
        req_i = 4'b0001;
        sb.push_back(mk(0, 64'h5A));
        wait_ack(20, got);
        req_i = '0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL empty_insert_timeout: no ack, required ack within 20 cycles");
        end else begin
            e = sb.pop_front();
            checks++;
            if (grant_o !== 2'(e.idx) || dato_o !== e.data) begin
                errors++;
                $display("FAIL empty_insert: grant=%0d dato=%h, required grant=0 dato=%h",
                         grant_o, dato_o, e.data);
            end
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (delecion_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL empty_one_delete: %0d pulses, required 1", pulses);
        end
        leer_i = 1'b0;
    endtask

    task automatic test_reset_mid_insert();
        bit got;
        exp_t e;
        reset_all();
        set_data(2, 64'h22);
        set_data(3, 64'h33);
        req_i = 4'b0100;
        @(negedge clk_i);
        rstn_i   = 1'b1;
        buf_rstn = 1'b1;
        wait_ack(20, got);
        wait_ack(20, got);
        checks++;
        if (!got || insercion_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got=%b ins=%b, required second insert in flight", got, insercion_o);
        end
        req_i  = 4'b1100;
        rstn_i = 1'b0;
        #1;
        checks++;
        if (insercion_o !== 1'b0 || ack_o !== '0 || grant_o !== '0 || dato_o !== '0) begin
            errors++;
            $display("FAIL mid_async_clear: ins=%b ack=%b grant=%0d dato=%h, required all zero",
                     insercion_o, ack_o, grant_o, dato_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        sb.push_back(mk(2, 64'h22));
        wait_ack(20, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL mid_timeout: no ack after reset, required ack within 20 cycles");
        end else begin
            e = sb.pop_front();
            checks++;
            if (ack_o !== (4'b1 << e.idx) || grant_o !== 2'(e.idx) || dato_o !== e.data) begin
                errors++;
                $display("FAIL mid_regrant: ack=%b grant=%0d dato=%h, required ack=0100 grant=2 dato=%h",
                         ack_o, grant_o, dato_o, e.data);
            end
        end
        req_i = '0;
    endtask

`ifdef ARB_CONTADORES_EN
    task automatic test_counters();
        bit got;
        logic [15:0] want;
        reset_all();
        set_data(1, 64'h11);
        set_data(3, 64'h33);
        req_i = 4'b0010;
        @(negedge clk_i);
        rstn_i   = 1'b1;
        buf_rstn = 1'b1;
        for (int n = 0; n < 7; n++) begin
            wait_ack(20, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL cnt_timeout: no ack %0d, required ack within 20 cycles", n);
                break;
            end
            if (n == 4) req_i = 4'b1000;
        end
        req_i = '0;
        repeat (4) @(negedge clk_i);
        for (int k = 0; k < NREQ; k++) begin
            want = (k == 1) ? 16'd5 : (k == 3) ? 16'd2 : 16'd0;
            checks++;
            if (cuenta_o[k*16 +: 16] !== want) begin
                errors++;
                $display("FAIL cnt_slot%0d: %0d, required %0d", k, cuenta_o[k*16 +: 16], want);
            end
        end
        borrar_cnt_i = 1'b1;
        @(negedge clk_i);
        borrar_cnt_i = 1'b0;
        checks++;
        if (cuenta_o !== '0) begin
            errors++;
            $display("FAIL cnt_clear: %h, required 0", cuenta_o);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_full();
        test_drain_from_full();
        test_empty_read();
        test_reset_mid_insert();
`ifdef ARB_CONTADORES_EN
        test_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
